// File: rtl/vec_mul_seq_ctrl_pkg.sv
// vec_mul_pkg: shared state encoding and defaults for the vector-multiplier run sequencer
package vec_mul_pkg;
  localparam int ADDR_W = 10;
  localparam int PIPE_LAT = 2;
  typedef enum logic [2:0] {S_IDLE, S_WFETCH, S_WLOAD, S_ISSUE, S_DRAIN, S_FINISH} state_t;
endpackage

// File: rtl/vec_mul_seq_ctrl_if.sv
// vec_mul_seq_ctrl_if: host/FIFO/UB/Results SRAM signals of the run sequencer
interface vec_mul_seq_ctrl_if #(parameter int AW = vec_mul_pkg::ADDR_W);
  logic start, abort, reload, fifo_empty;
  logic [AW-1:0] num_vectors, src_base, dst_base;
  logic fifo_read_enable, weight_reload, res_write_enable, busy, done;
  logic [AW-1:0] ub_address, res_address;
  modport master (
    output start, abort, reload, num_vectors, src_base, dst_base, fifo_empty,
    input fifo_read_enable, weight_reload, ub_address, res_write_enable, res_address, busy, done
  );
  modport slave (
    input start, abort, reload, num_vectors, src_base, dst_base, fifo_empty,
    output fifo_read_enable, weight_reload, ub_address, res_write_enable, res_address, busy, done
  );
endinterface

// File: rtl/vec_mul_seq_ctrl_valid_delay_line.sv
// valid_delay_line: DEPTH-stage 1-bit shift register tracking results still in the datapath
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_in,
  output logic o_out,
  output logic o_empty
);
  logic [DEPTH-1:0] r_sr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_sr <= '0;
    else r_sr <= i_clr ? '0 : (r_sr << 1) | DEPTH'(i_in);
  assign o_out = r_sr[DEPTH-1];
  assign o_empty = ~|r_sr;
endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// vec_mul_seq_ctrl: sequences weight reload, UB address streaming and delayed Results SRAM writes
module vec_mul_seq_ctrl
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDR_W,
  parameter int PIPE_LATENCY = PIPE_LAT
) (
  input logic clk,
  input logic rstn,
  vec_mul_seq_ctrl_if.slave bus
);
  localparam logic [ADDRESSSIZE-1:0] ONE = ADDRESSSIZE'(1);
  state_t r_state, w_next;
  logic [ADDRESSSIZE-1:0] r_n, r_icnt, r_ub, r_wa;
  logic r_wl, r_wen, r_busy, r_done;
  logic w_accept, w_pop, w_dl_out, w_dl_empty;
  assign w_accept = r_state == S_IDLE && bus.start && !bus.abort;
  assign w_pop = r_state == S_WFETCH && !bus.fifo_empty && !bus.abort;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = bus.reload ? S_WFETCH : bus.num_vectors == '0 ? S_FINISH : S_ISSUE;
      S_WFETCH: if (!bus.fifo_empty) w_next = S_WLOAD;
      S_WLOAD:  w_next = r_n == '0 ? S_FINISH : S_ISSUE;
      S_ISSUE:  if (r_icnt == r_n - ONE) w_next = S_DRAIN;
      S_DRAIN:  if (w_dl_empty) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  // strobes are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_n <= '0;
      r_icnt <= '0;
      r_ub <= '0;
      r_wa <= '0;
      r_wl <= 1'b0;
      r_wen <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n <= bus.num_vectors;
        r_icnt <= '0;
        r_ub <= bus.src_base;
      end else if (r_state == S_ISSUE) begin
        r_icnt <= r_icnt + ONE;
        r_ub <= r_ub + ONE;
      end
      r_wa <= w_accept ? bus.dst_base : r_wen ? r_wa + ONE : r_wa;
      r_wl <= w_next == S_WLOAD;
      r_wen <= w_dl_out && !bus.abort;
      r_busy <= w_next != S_IDLE;
      r_done <= w_next == S_FINISH;
    end
  // one extra output register after the delay line gives the full PIPE_LATENCY alignment
  valid_delay_line #(.DEPTH(PIPE_LATENCY)) u_vdl (
    .clk(clk),
    .rstn(rstn),
    .i_clr(bus.abort),
    .i_in(w_next == S_ISSUE),
    .o_out(w_dl_out),
    .o_empty(w_dl_empty)
  );
  assign bus.fifo_read_enable = w_pop;
  assign bus.weight_reload = r_wl;
  assign bus.ub_address = r_ub;
  assign bus.res_write_enable = r_wen;
  assign bus.res_address = r_wa;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// tb_vec_mul_seq_ctrl: table-driven and randomized runs checked against a run-timeline model
module tb_vec_mul_seq_ctrl;
  import vec_mul_pkg::*;
  localparam int L = PIPE_LAT;
  localparam int AW = ADDR_W;
  typedef logic [AW-1:0] addr_t;
  typedef struct {
    addr_t src, dst, n;
    bit rl;
    int w, x_wr, x_done;
    addr_t x_last;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t tab[7];
  vec_mul_seq_ctrl_if #(.AW(AW)) bus ();
  vec_mul_seq_ctrl #(.ADDRESSSIZE(AW), .PIPE_LATENCY(L)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int t, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s t=%0d got=0x%0h want=0x%0h", nm, t, act, exp);
  endtask

  task automatic drive_rand();
    bus.num_vectors = addr_t'($urandom);
    bus.src_base = addr_t'($urandom);
    bus.dst_base = addr_t'($urandom);
    bus.reload = 1'($urandom);
  endtask

  task automatic chk_quiet(input string nm, input int t);
    chk({nm, "_busy"}, t, int'(bus.busy), 0);
    chk({nm, "_wen"}, t, int'(bus.res_write_enable), 0);
    chk({nm, "_done"}, t, int'(bus.done), 0);
    chk({nm, "_pop"}, t, int'(bus.fifo_read_enable), 0);
    chk({nm, "_wload"}, t, int'(bus.weight_reload), 0);
  endtask

  task automatic idle(input int k, input bit sa);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      drive_rand();
      bus.start = sa;
      bus.abort = sa;
      bus.fifo_empty = 1'($urandom);
      #1;
      chk_quiet("idle", i);
    end
  endtask

  // expected outputs derived from the run timeline: offset o for the weight fetch, done at d
  task automatic run(input addr_t src, input addr_t dst, input addr_t n, input bit rl, input int w,
                     input int ab_in, input int rs, input int x_wr, input int x_done, input addr_t x_last);
    int o, d, ab, stop, nwr, tdone;
    addr_t last;
    bit e_wen;
    o = rl ? 2 + w : 0;
    d = (n == '0) ? o + 1 : o + int'(n) + L + 1;
    ab = (ab_in == -2) ? (($urandom % 5 == 0) ? int'($urandom_range(1, d)) : -1) : ab_in;
    stop = ab >= 0 ? ab : rs >= 0 ? rs : d;
    nwr = 0;
    tdone = -1;
    last = '0;
    for (int t = 0; t <= stop; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.start = 1'b1;
        bus.num_vectors = n;
        bus.src_base = src;
        bus.dst_base = dst;
        bus.reload = rl;
      end else begin
        drive_rand();
        bus.start = ($urandom % 3 == 0);
      end
      bus.abort = (t == ab);
      bus.fifo_empty = (rl && t >= 1 && t <= w) ? 1'b1 : (rl && t == w + 1) ? 1'b0 : 1'($urandom);
      #1;
      e_wen = n != '0 && t >= o + 1 + L && t <= o + int'(n) + L;
      chk("pop", t, int'(bus.fifo_read_enable), int'(rl && t == 1 + w && t != ab));
      chk("wload", t, int'(bus.weight_reload), int'(rl && t == 2 + w));
      chk("busy", t, int'(bus.busy), int'(t >= 1 && t <= d));
      chk("done", t, int'(bus.done), int'(t == d));
      chk("wen", t, int'(bus.res_write_enable), int'(e_wen));
      if (e_wen) chk("res_addr", t, int'(bus.res_address), int'(addr_t'(int'(dst) + t - o - 1 - L)));
      if (n != '0 && t >= o + 1 && t <= o + int'(n))
        chk("ub_addr", t, int'(bus.ub_address), int'(addr_t'(int'(src) + t - o - 1)));
      if (bus.res_write_enable) begin
        nwr++;
        last = bus.res_address;
      end
      if (bus.done) tdone = t;
      if (t == rs) begin
        #2 rstn = 1'b0;
        #1;
        chk_quiet("rst", t);
        chk("rst_ub", t, int'(bus.ub_address), 0);
        chk("rst_res", t, int'(bus.res_address), 0);
      end
    end
    if (ab < 0 && rs < 0 && x_wr >= 0) begin
      chk("n_writes", d, nwr, x_wr);
      chk("done_t", d, tdone, x_done);
      if (x_wr > 0) chk("last_res", d, int'(last), int'(x_last));
    end
  endtask

  initial begin
    tab[0] = '{10'h010, 10'h020, 10'd4, 1'b0, 0, 4, 7, 10'h023};
    tab[1] = '{10'h3FE, 10'h3FF, 10'd3, 1'b0, 0, 3, 6, 10'h001};
    tab[2] = '{10'h000, 10'h000, 10'd0, 1'b0, 0, 0, 1, 10'h000};
    tab[3] = '{10'h100, 10'h200, 10'd0, 1'b1, 0, 0, 3, 10'h000};
    tab[4] = '{10'h055, 10'h0AA, 10'd2, 1'b1, 5, 2, 12, 10'h0AB};
    tab[5] = '{10'h3FF, 10'h000, 10'd1, 1'b1, 0, 1, 6, 10'h000};
    tab[6] = '{10'h123, 10'h3FC, 10'd6, 1'b0, 0, 6, 9, 10'h001};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.fifo_empty = 1'b0;
    drive_rand();
    @(negedge clk);
    chk_quiet("reset", 0);
    chk("reset_ub", 0, int'(bus.ub_address), 0);
    chk("reset_res", 0, int'(bus.res_address), 0);
    rstn = 1'b1;
    idle(2, 1'b0);
    for (int i = 0; i < 7; i++)
      run(tab[i].src, tab[i].dst, tab[i].n, tab[i].rl, tab[i].w, -1, -1, tab[i].x_wr, tab[i].x_done, tab[i].x_last);
    idle(3, 1'b0);
    run(10'h000, 10'h040, 10'd8, 1'b0, 0, 4, -1, -1, 0, '0);
    run(tab[0].src, tab[0].dst, tab[0].n, 1'b0, 0, -1, -1, tab[0].x_wr, tab[0].x_done, tab[0].x_last);
    idle(1, 1'b1);
    idle(3, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run(addr_t'($urandom), addr_t'($urandom), addr_t'($urandom_range(0, 12)), 1'($urandom),
          int'($urandom_range(0, 3)), -2, -1, -1, 0, '0);
      if ($urandom % 4 == 0) idle(int'($urandom_range(1, 3)), 1'b0);
    end
    run(10'h0F0, 10'h1F0, 10'd3, 1'b0, 0, -1, 4, -1, 0, '0);
    @(negedge clk);
    chk_quiet("in_reset", 0);
    rstn = 1'b1;
    idle(6, 1'b0);
    run(tab[6].src, tab[6].dst, tab[6].n, 1'b0, 0, -1, -1, tab[6].x_wr, tab[6].x_done, tab[6].x_last);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vec_mul_seq_ctrl.md
# vec_mul_seq_ctrl

Parametrised run sequencer for the vector-multiplier datapath. It replaces the free-running counter / delayed-valid glue between the Unified Buffer, Weight FIFO, vec_mul array and Results SRAM. The host issues a single `start` with a source base, destination base, vector count and reload flag. The block optionally pulls one weight tile from the FIFO, streams UB read addresses one per cycle, and writes each result to the Results SRAM exactly `PIPE_LATENCY` cycles later. It finishes with a `done` pulse and supports abort.

## Interface
- `ADDRESSSIZE`, 10, width of UB and Results SRAM addresses and of the vector count.
- `PIPE_LATENCY`, 2, cycles from a UB address being driven to the matching result being valid at the Results SRAM input; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: run request; sampled only in IDLE.
- `abort` in 1: cancel the current run; has priority over everything else.
- `reload` in 1: fetch new weights before streaming; sampled with `start`.
- `num_vectors` in ADDRESSSIZE: vectors to process; sampled with `start`.
- `src_base` in ADDRESSSIZE: first UB address; sampled with `start`.
- `dst_base` in ADDRESSSIZE: first Results SRAM address; sampled with `start`.
- `fifo_empty` in 1: Weight FIFO empty flag.
- `fifo_read_enable` out 1: one-cycle FIFO pop.
- `weight_reload` out 1: one-cycle weight latch strobe to vec_mul.
- `ub_address` out ADDRESSSIZE: UB read address.
- `res_write_enable` out 1: Results SRAM write strobe.
- `res_address` out ADDRESSSIZE: Results SRAM write address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE.
  - WFETCH.
  - WLOAD.
  - ISSUE.
  - DRAIN.
  - FINISH.
- From IDLE:
  - `start`=1 latches `num_vectors`, `src_base`, `dst_base` and `reload`.
  - Next state is WFETCH if `reload`=1.
  - Otherwise next state is FINISH if `num_vectors`=0.
  - Otherwise next state is ISSUE.
- WFETCH: `fifo_read_enable` = !`fifo_empty` (combinational). When it is asserted, go to WLOAD. While the FIFO is empty, stay in WFETCH indefinitely.
- WLOAD: `weight_reload`=1 for exactly one cycle. Next state is FINISH if the latched count is 0, else ISSUE.
- ISSUE:
  - Each cycle, `ub_address` = `src_base` + issued count (mod 2^ADDRESSSIZE), and a 1 is pushed into the valid delay line.
  - After N addresses, go to DRAIN.
- DRAIN: wait until the valid delay line is empty, then go to FINISH.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- Result side:
  - `res_write_enable` is the delay-line output.
  - `res_address` starts at `dst_base` and increments after each write, wrapping mod 2^ADDRESSSIZE.
- `abort`: in any state, the next state is IDLE and the delay line is cleared. No further writes and no `done` are produced.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: abort wins and the block stays IDLE.
- Reset values: every output 0, state IDLE, delay line cleared, counters 0.

## Timing
- All outputs are registered except `fifo_read_enable`.
- `start` at cycle T, `reload`=0, N≥1:
  - `ub_address` = `src_base` at T+1 … T+N.
  - `res_write_enable` high T+1+PIPE_LATENCY … T+N+PIPE_LATENCY.
  - `done` at T+N+PIPE_LATENCY+1.
  - `busy` high T+1 through the `done` cycle.
- `reload`=1 with the FIFO non-empty: pop at T+1, `weight_reload` at T+2, first address at T+3. All subsequent events shift by +2.
- N=0, `reload`=0: `done` at T+1; no address or write activity.
- Back-to-back runs: `start` at the cycle after `done` is accepted.
- Asynchronous reset mid-run: outputs go to 0 immediately, with no pending writes after release.

## Structure
- Package `vec_mul_pkg`: state enum (6 states, 3-bit encoding), `PIPE_LATENCY` default, address-width constant.
- Sub-module `valid_delay_line`:
  - PIPE_LATENCY-deep 1-bit shift register with a synchronous clear.
  - Outputs an `empty` flag (OR-reduction, inverted).
- Counters (issue, write) live in the top module; no arithmetic is wider than ADDRESSSIZE.

## Test plan
- `src_base`=0x010, `dst_base`=0x020, N=4, `reload`=0 -> `ub_address` 0x010..0x013 at T+1..T+4; writes to 0x020..0x023 at T+3..T+6; `done` at T+7.
- `reload`=1, `fifo_empty` held 1 for 5 cycles then 0 -> stays in WFETCH with `busy`=1; a single-cycle pop, then `weight_reload` on the next cycle, then streaming.
- `src_base`=0x3FE, `dst_base`=0x3FF, N=3 -> UB addresses 0x3FE, 0x3FF, 0x000; results to 0x3FF, 0x000, 0x001.
- N=0, `reload`=0 -> `done` at T+1, no writes; N=0, `reload`=1 -> pop and reload, then `done`.
- N=8, `abort` at T+4 -> IDLE at T+5, zero writes after T+5, no `done`; a new `start` at T+5 runs normally.
- `start` pulsed during ISSUE and `rstn` dropped mid-DRAIN -> the extra `start` is ignored; reset clears all outputs within the same cycle, with no writes after reset release.
